// File: rtl/asynchronous_fifo_pkg.sv
// Shared sizing defaults for the FWFT FIFO and its storage array.
package asynchronous_fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 7;

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

endpackage

// File: rtl/asynchronous_fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read, no reset on contents.
module fifo_mem
    import asynchronous_fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ASIZE-1:0] wr_addr,
    input  logic [DSIZE-1:0] wr_data,
    input  logic [ASIZE-1:0] rd_addr,
    output logic [DSIZE-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/asynchronous_fifo.sv
// First-word-fall-through FIFO, single clock; pointers carry an extra wrap bit
// so full and empty are distinguishable without an occupancy counter.
module asynchronous_fifo
    import asynchronous_fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [DSIZE-1:0] wr_data,
    output logic [DSIZE-1:0] rd_data,
    output logic             o_fifo_full,
    output logic             o_fifo_empty
);

    logic [ASIZE:0]   wr_ptr, rd_ptr;
    logic [DSIZE-1:0] mem_rd_data;
    logic             do_wr, do_rd;

    assign o_fifo_empty = (wr_ptr == rd_ptr);
    assign o_fifo_full  = (wr_ptr[ASIZE] != rd_ptr[ASIZE]) &&
                          (wr_ptr[ASIZE-1:0] == rd_ptr[ASIZE-1:0]);

    // Reset also blocks the array write so a concurrent wr_en leaves no trace.
    assign do_wr = wr_en && !o_fifo_full && !rst;
    assign do_rd = rd_en && !o_fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_wr),
        .wr_addr (wr_ptr[ASIZE-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[ASIZE-1:0]),
        .rd_data (mem_rd_data)
    );

    // Head word falls through; force zero while empty so stale entries never leak.
    assign rd_data = o_fifo_empty ? '0 : mem_rd_data;

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Directed and scoreboard checks for the FWFT FIFO at default sizing (8 x 128).
module tb_asynchronous_fifo;

    localparam int DSIZE = 8;
    localparam int ASIZE = 7;
    localparam int DEPTH = 128;

    logic             clk = 1'b0;
    logic             rst, wr_en, rd_en;
    logic [DSIZE-1:0] wr_data;
    logic [DSIZE-1:0] rd_data;
    logic             o_fifo_full, o_fifo_empty;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DSIZE-1:0] q [$];

    asynchronous_fifo #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .wr_data      (wr_data),
        .rd_data      (rd_data),
        .o_fifo_full  (o_fifo_full),
        .o_fifo_empty (o_fifo_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DSIZE-1:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        #2;

        // Reset state and basic fall-through
        do_reset(5);
        chk("rst_empty", o_fifo_empty, 1);
        chk("rst_full",  o_fifo_full, 0);
        chk("rst_rdata", rd_data, 0);
        push(8'hA5);
        chk("first_empty", o_fifo_empty, 0);
        chk("first_head", rd_data, 8'hA5);
        push(8'h3C);
        chk("head_a5", rd_data, 8'hA5);
        pop();
        chk("head_3c", rd_data, 8'h3C);
        pop();
        chk("drained_empty", o_fifo_empty, 1);
        chk("drained_rdata", rd_data, 0);

        // Fill to full, overflow attempt, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("full_before_last", o_fifo_full, 0);
            push(i[7:0]);
        end
        chk("fill_full", o_fifo_full, 1);
        chk("fill_head", rd_data, 8'h00);
        push(8'hFF);
        chk("ovf_full", o_fifo_full, 1);
        chk("ovf_head", rd_data, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_data", rd_data, i);
            pop();
            if (i == 0) chk("drain_notfull", o_fifo_full, 0);
        end
        chk("drain_empty", o_fifo_empty, 1);
        chk("drain_rdata", rd_data, 0);

        // Underflow is ignored
        rd_en = 1'b1;
        repeat (3) begin
            tick();
            chk("udf_empty", o_fifo_empty, 1);
        end
        rd_en = 1'b0;
        push(8'h11);
        chk("udf_head", rd_data, 8'h11);
        pop();
        chk("udf_empty_after", o_fifo_empty, 1);

        // Simultaneous read/write at occupancy 4
        q.delete();
        for (int i = 1; i <= 4; i++) begin
            push(i[7:0]);
            q.push_back(i[7:0]);
        end
        for (int i = 0; i < 10; i++) begin
            chk("sim_head", rd_data, q[0]);
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h10 + i[7:0];
            tick();
            void'(q.pop_front());
            q.push_back(8'h10 + i[7:0]);
            chk("sim_empty", o_fifo_empty, 0);
            chk("sim_full",  o_fifo_full, 0);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("sim_drain", rd_data, q.pop_front());
            pop();
        end
        chk("sim_occ4_empty", o_fifo_empty, 1);

        // Simultaneous read/write while full: read wins, write dropped
        for (int i = 0; i < DEPTH; i++) push(i[7:0]);
        chk("fullrw_pre", o_fifo_full, 1);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("fullrw_full", o_fifo_full, 0);
        chk("fullrw_head", rd_data, 8'h01);
        for (int i = 1; i < DEPTH; i++) begin
            chk("fullrw_drain", rd_data, i);
            pop();
        end
        chk("fullrw_empty", o_fifo_empty, 1);

        // Random scoreboard across several pointer wraps
        begin
            int nw = 0;
            int cyc = 0;
            logic [DSIZE-1:0] d;
            q.delete();
            while ((nw < 400 || q.size() != 0) && cyc < 5000) begin
                wr_en = 1'b0; rd_en = 1'b0;
                if (cyc % 2 == 0 && nw < 400 && q.size() < DEPTH) begin
                    d = 8'($urandom_range(0, 255));
                    wr_en = 1'b1; wr_data = d;
                end
                if (cyc % 4 == 0 && q.size() != 0) begin
                    rd_en = 1'b1;
                    chk("sb_data", rd_data, q.pop_front());
                end
                if (wr_en) begin
                    q.push_back(d);
                    nw++;
                end
                tick();
                chk("sb_empty", o_fifo_empty, q.size() == 0);
                chk("sb_full",  o_fifo_full,  q.size() == DEPTH);
                cyc++;
            end
            wr_en = 1'b0; rd_en = 1'b0;
            chk("sb_timeout", cyc < 5000, 1);
        end

        // Mid-operation reset
        for (int i = 0; i < 50; i++) push(8'h80 + i[7:0]);
        chk("mid_pre_head", rd_data, 8'h80);
        do_reset(1);
        chk("mid_empty", o_fifo_empty, 1);
        chk("mid_full",  o_fifo_full, 0);
        chk("mid_rdata", rd_data, 0);
        push(8'h42);
        chk("mid_head", rd_data, 8'h42);

        // Reset overrides a concurrent write
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        chk("rstwr_empty", o_fifo_empty, 1);
        chk("rstwr_rdata", rd_data, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
